// File: rtl/ram_bist.sv
// March-style BIST master for RAM_array: writes P0, reads back, then repeats with P1 = ~P0,
// counting mismatches and latching the first failing address and phase.
module ram_bist #(
    parameter int unsigned       ADDR_W = 8,
    parameter int unsigned       DATA_W = 8,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(8'hAF)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DATA_IN,
    output logic              WE,
    input  logic [DATA_W-1:0] DATA_OUT1,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [ADDR_W+1:0] ERR_COUNT,
    output logic [ADDR_W-1:0] FAIL_ADDR,
    output logic              FAIL_PHASE
);

    typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, FIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ADDR_W+1:0]   err_q, err_d;
    logic [ADDR_W-1:0]   fa_q, fa_d;
    logic                fp_q, fp_d;
    logic                seen_q, seen_d;
    logic                rd_phase;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic inv);
        logic [DATA_W-1:0] p;
        p = DATA_W'(a) ^ SEED;
        return inv ? ~p : p;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fa_q    <= '0;
            fp_q    <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fa_q    <= fa_d;
            fp_q    <= fp_d;
            seen_q  <= seen_d;
        end
    end

    // The extra counter bit carries out of the last address and marks the end of a phase.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        we_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fa_d     = fa_q;
        fp_d     = fp_q;
        seen_d   = seen_q;
        cnt_inc  = cnt_q + 1'b1;
        rd_phase = (state_q == RD1);

        case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    state_d = WR0;
                    cnt_d   = '0;
                    data_d  = pattern('0, 1'b0);
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fa_d    = '0;
                    fp_d    = 1'b0;
                    seen_d  = 1'b0;
                end
            end
            WR0, WR1: begin
                if (cnt_inc[ADDR_W]) begin
                    state_d = (state_q == WR0) ? RD0 : RD1;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_inc;
                    we_d   = 1'b1;
                    data_d = pattern(cnt_inc[ADDR_W-1:0], state_q == WR1);
                end
            end
            RD0, RD1: begin
                if (DATA_OUT1 != pattern(cnt_q[ADDR_W-1:0], rd_phase)) begin
                    err_d = err_q + 1'b1;
                    if (!seen_q) begin
                        seen_d = 1'b1;
                        fa_d   = cnt_q[ADDR_W-1:0];
                        fp_d   = rd_phase;
                    end
                end
                if (cnt_inc[ADDR_W]) begin
                    cnt_d = '0;
                    if (state_q == RD0) begin
                        state_d = WR1;
                        we_d    = 1'b1;
                        data_d  = pattern('0, 1'b1);
                    end else begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ADDR       = cnt_q[ADDR_W-1:0];
    assign DATA_IN    = data_q;
    assign WE         = we_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign PASS       = pass_q;
    assign ERR_COUNT  = err_q;
    assign FAIL_ADDR  = fa_q;
    assign FAIL_PHASE = fp_q;

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: behavioural RAM with read-path fault injection, directed vector table,
// multi-cycle corner sequences and randomized faults checked against an abstract result model.
module tb_ram_bist;

    typedef struct packed {
        logic [7:0] or_m;
        logic [7:0] and_m;
        logic [7:0] x_addr;
        logic [7:0] x_mask;
        logic       x_en;
    } fault_t;

    typedef struct {
        string  name;
        fault_t f;
        int     exp_err;
        int     exp_fa;
        int     exp_fp;
        bit     exp_pass;
    } vec_t;

    localparam fault_t GOOD = '{8'h00, 8'hFF, 8'h00, 8'h00, 1'b0};

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [7:0] ADDR, DATA_IN, DATA_OUT1, FAIL_ADDR;
    logic       WE, BUSY, DONE, PASS, FAIL_PHASE;
    logic [9:0] ERR_COUNT;

    fault_t     flt = GOOD;
    logic [7:0] mem [256];
    int         total = 0;
    int         bad = 0;

    always #5 CLK = ~CLK;

    ram_bist #(.ADDR_W(8), .DATA_W(8), .SEED(8'hAF)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .ADDR(ADDR), .DATA_IN(DATA_IN), .WE(WE), .DATA_OUT1(DATA_OUT1),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_COUNT(ERR_COUNT),
        .FAIL_ADDR(FAIL_ADDR), .FAIL_PHASE(FAIL_PHASE)
    );

    function automatic logic [7:0] corrupt(input fault_t f, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        r = (d | f.or_m) & f.and_m;
        if (f.x_en && a == f.x_addr) r = r ^ f.x_mask;
        return r;
    endfunction

    always @(posedge CLK) if (WE) mem[ADDR] <= DATA_IN;
    always_comb DATA_OUT1 = corrupt(flt, ADDR, mem[ADDR]);

    function automatic int pat(input int a, input int ph);
        int p;
        p = (a % 256) ^ 'hAF;
        if (ph != 0) p = p ^ 'hFF;
        return p;
    endfunction

    // Expected results: sweep both phases, compare ideal data with what the faulty read returns.
    task automatic model(input fault_t f, output int err, output int fa, output int fp);
        logic [7:0] w, r;
        err = 0; fa = 0; fp = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < 256; a++) begin
                w = 8'(pat(a, ph));
                r = corrupt(f, 8'(a), w);
                if (r != w) begin
                    if (err == 0) begin fa = a; fp = ph; end
                    err++;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_results(input string tag, input int err, input int fa, input int fp, input bit ps);
        check({tag, ".err"}, ERR_COUNT, err);
        check({tag, ".fail_addr"}, FAIL_ADDR, fa);
        check({tag, ".fail_phase"}, FAIL_PHASE, fp);
        check({tag, ".pass"}, PASS, ps);
    endtask

    // Starts a run and follows it cycle by cycle; j counts edges after the accepting edge.
    task automatic run_bist(input int pulse_at, input int rst_at, input bit chk_pat, output int lat);
        int  trace_bad;
        int  first_bad;
        bit  exp_we;
        trace_bad = 0;
        first_bad = -1;
        lat = -1;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        for (int j = 0; j <= 1100; j++) begin
            if (DONE) begin lat = j; break; end
            exp_we = (j < 256) || (j >= 512 && j < 768);
            if (WE !== exp_we || ADDR !== 8'(j % 256) || BUSY !== 1'b1 ||
                (exp_we && DATA_IN !== 8'(pat(j % 256, int'(j >= 512))))) begin
                if (trace_bad == 0) first_bad = j;
                trace_bad++;
            end
            if (chk_pat && j == 3) begin
                check("wr0_addr3", ADDR, 3);
                check("wr0_data3", DATA_IN, 8'hAC);
            end
            if (chk_pat && j == 515) begin
                check("wr1_addr3", ADDR, 3);
                check("wr1_data3", DATA_IN, 8'h53);
            end
            if (j == rst_at) begin
                #2 RST = 1'b1;
                #1;
                check("midrst.we", WE, 0);
                check("midrst.busy", BUSY, 0);
                check("midrst.addr", ADDR, 0);
                check("midrst.err", ERR_COUNT, 0);
                @(posedge CLK); #2 RST = 1'b0;
                repeat (3) @(negedge CLK);
                check("midrst.idle_busy", BUSY, 0);
                check("midrst.idle_we", WE, 0);
                check("midrst.idle_done", DONE, 0);
                lat = -2;
                break;
            end
            START = (j == pulse_at);
            @(negedge CLK);
        end
        START = 1'b0;
        check($sformatf("trace(first_bad_cycle=%0d)", first_bad), trace_bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs[6];
        int     lat, e_err, e_fa, e_fp;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        vecs[0] = '{"good",        GOOD,                                       0,     0,     0, 1'b1};
        vecs[1] = '{"stuck0_bit0", '{8'h00, 8'hFE, 8'h00, 8'h00, 1'b0},      256,     0,     0, 1'b0};
        vecs[2] = '{"inv_at_40",   '{8'h00, 8'hFF, 8'h40, 8'hFF, 1'b1},        2, 'h40,     0, 1'b0};
        vecs[3] = '{"stuck1_bit7", '{8'h80, 8'hFF, 8'h00, 8'h00, 1'b0},      256, 'h80,     0, 1'b0};
        vecs[4] = '{"flip_at_00",  '{8'h00, 8'hFF, 8'h00, 8'h08, 1'b1},        2,     0,     0, 1'b0};
        vecs[5] = '{"flip_at_ff",  '{8'h00, 8'hFF, 8'hFF, 8'h01, 1'b1},        2, 'hFF,     0, 1'b0};

        // Reset state, then release with START low.
        repeat (3) @(negedge CLK);
        check("rst.addr", ADDR, 0);
        check("rst.data_in", DATA_IN, 0);
        check("rst.we", WE, 0);
        check("rst.busy", BUSY, 0);
        check("rst.done", DONE, 0);
        check("rst.pass", PASS, 0);
        check("rst.err", ERR_COUNT, 0);
        check("rst.fail_addr", FAIL_ADDR, 0);
        check("rst.fail_phase", FAIL_PHASE, 0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("idle.busy", BUSY, 0);
        check("idle.we", WE, 0);
        check("idle.done", DONE, 0);

        foreach (vecs[i]) begin
            flt = vecs[i].f;
            run_bist(-1, -1, i == 0, lat);
            check({vecs[i].name, ".latency"}, lat, 1024);
            check_results(vecs[i].name, vecs[i].exp_err, vecs[i].exp_fa, vecs[i].exp_fp, vecs[i].exp_pass);
        end

        // START while busy is ignored and does not shift completion.
        flt = GOOD;
        run_bist(100, -1, 1'b0, lat);
        check("ignore_start.latency", lat, 1024);
        check_results("ignore_start", 0, 0, 0, 1'b1);

        // Reset at cycle 300, then a clean run.
        run_bist(-1, 300, 1'b0, lat);
        check("midrst.aborted", lat, -2);
        run_bist(-1, -1, 1'b0, lat);
        check("after_rst.latency", lat, 1024);
        check_results("after_rst", 0, 0, 0, 1'b1);

        // Failing run, then START held in FIN restarts with cleared results.
        flt = vecs[2].f;
        run_bist(-1, -1, 1'b0, lat);
        check_results("pre_hold", 2, 'h40, 0, 1'b0);
        flt = GOOD;
        START = 1'b1;
        @(negedge CLK);
        check("hold.done", DONE, 0);
        check("hold.busy", BUSY, 1);
        check("hold.err", ERR_COUNT, 0);
        check("hold.fail_addr", FAIL_ADDR, 0);
        lat = -1;
        for (int j = 1; j <= 1100; j++) begin
            @(negedge CLK);
            if (j == 5) START = 1'b0;
            if (DONE) begin lat = j; break; end
        end
        START = 1'b0;
        check("hold.latency", lat, 1024);
        check_results("hold", 0, 0, 0, 1'b1);

        // Randomized read-path faults against the abstract model.
        for (int r = 0; r < 4; r++) begin
            flt.or_m   = ($urandom_range(0, 2) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'h00;
            flt.and_m  = ($urandom_range(0, 2) == 0) ? ~(8'd1 << $urandom_range(0, 7)) : 8'hFF;
            flt.x_en   = 1'($urandom_range(0, 1));
            flt.x_addr = 8'($urandom);
            flt.x_mask = 8'($urandom_range(1, 255));
            model(flt, e_err, e_fa, e_fp);
            run_bist(-1, -1, 1'b0, lat);
            check($sformatf("rand%0d.latency", r), lat, 1024);
            check_results($sformatf("rand%0d", r), e_err, e_fa, e_fp, e_err == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
